// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter feeding a shared multi-cycle signed ALU.
// One operation is in flight at a time; its result is held until acknowledged.
module alu_arbiter #(
  parameter int NBITS = 3,
  parameter int LAT   = 2
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              op0,
  input  logic [1:0]              op1,
  input  logic signed [NBITS-1:0] a0,
  input  logic signed [NBITS-1:0] b0,
  input  logic signed [NBITS-1:0] a1,
  input  logic signed [NBITS-1:0] b1,
  input  logic                    res_ack,
  output logic [1:0]              gnt,
  output logic                    busy,
  output logic                    res_valid,
  output logic signed [NBITS-1:0] result,
  output logic                    overflow,
  output logic                    res_id
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt, w_cnt_nxt;
  logic [1:0]              r_gnt, w_gnt_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_valid, w_valid_nxt;
  logic signed [NBITS-1:0] r_result, w_result_nxt;
  logic                    r_ovf, w_ovf_nxt;
  logic                    r_id, w_id_nxt;
  logic                    r_last, w_last_nxt;
  logic [1:0]              r_op, w_op_nxt;
  logic signed [NBITS-1:0] r_a, w_a_nxt;
  logic signed [NBITS-1:0] r_b, w_b_nxt;

  logic                    w_win;
  logic signed [NBITS-1:0] w_alu;
  logic                    w_alu_ovf;

  // ALU on the operands latched at grant
  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (r_op)
      2'b00: begin
        w_alu     = r_a + r_b;
        w_alu_ovf = (r_a[NBITS-1] == r_b[NBITS-1]) && (w_alu[NBITS-1] != r_a[NBITS-1]);
      end
      2'b01: begin
        w_alu     = r_a - r_b;
        w_alu_ovf = (r_a[NBITS-1] != r_b[NBITS-1]) && (w_alu[NBITS-1] != r_a[NBITS-1]);
      end
      2'b10:   w_alu = r_a & r_b;
      default: w_alu = r_a | r_b;
    endcase
  end

  // Round-robin winner: lone requester wins, a tie goes to the one not granted last
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = '0;
    w_valid_nxt  = r_valid;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_id_nxt     = r_id;
    w_last_nxt   = r_last;
    w_op_nxt     = r_op;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_op_nxt    = w_win ? op1 : op0;
          w_a_nxt     = w_win ? a1 : a0;
          w_b_nxt     = w_win ? b1 : b0;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_cnt_nxt   = CNT_INIT;
          w_id_nxt    = w_win;
          w_last_nxt  = w_win;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_result_nxt = w_alu;
          w_ovf_nxt    = w_alu_ovf;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        if (res_ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_busy   <= w_busy_nxt;
      r_valid  <= w_valid_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_id     <= w_id_nxt;
      r_last   <= w_last_nxt;
      r_op     <= w_op_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign res_valid = r_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign res_id    = r_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expectations are pushed at grant, popped at res_valid.
module tb_alu_arbiter;

  localparam int NBITS = 3;
  localparam int LAT   = 2;

  logic                    clk_2 = 1'b0;
  logic                    reset;
  logic [1:0]              req;
  logic [1:0]              op0, op1;
  logic signed [NBITS-1:0] a0, b0, a1, b1;
  logic                    res_ack;
  logic [1:0]              gnt;
  logic                    busy, res_valid, overflow, res_id;
  logic signed [NBITS-1:0] result;

  typedef struct packed {
    logic             id;
    logic [NBITS-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_id;

  alu_arbiter #(.NBITS(NBITS), .LAT(LAT)) dut (
    .clk_2(clk_2), .reset(reset), .req(req), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .res_ack(res_ack),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .result(result),
    .overflow(overflow), .res_id(res_id)
  );

  always #5 clk_2 = ~clk_2;

  function automatic exp_t model(input logic id, input logic [1:0] op,
                                 input logic signed [NBITS-1:0] a,
                                 input logic signed [NBITS-1:0] b);
    exp_t e;
    int   s;
    int   maxv;
    int   minv;
    maxv  = (1 << (NBITS - 1)) - 1;
    minv  = -(1 << (NBITS - 1));
    e.id  = id;
    e.ovf = 1'b0;
    e.res = '0;
    s     = 0;
    case (op)
      2'b00, 2'b01: begin
        s     = (op == 2'b00) ? (int'(a) + int'(b)) : (int'(a) - int'(b));
        e.res = s[NBITS-1:0];
        e.ovf = (s > maxv) || (s < minv);
      end
      2'b10:   e.res = a & b;
      default: e.res = a | b;
    endcase
    return e;
  endfunction

  // One full transaction: request, grant, latency, result, optional hold, ack.
  task automatic issue(input logic [1:0] reqv, input logic hold,
                       input logic exec_ack, input int ack_delay);
    logic       exp_id;
    logic [1:0] exp_gnt;
    logic       got;
    int         k;
    exp_t       e;
    exp_id  = (reqv == 2'b01) ? 1'b0 : (reqv == 2'b10) ? 1'b1 : ~last_id;
    exp_gnt = exp_id ? 2'b10 : 2'b01;
    req     = reqv;
    got     = 1'b0;
    k       = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_2); #1;
      k = i;
      if (gnt != 2'b00) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      $display("FAIL grant_timeout: gnt=%b required=%b", gnt, exp_gnt);
      n_fail++;
      req = '0;
      return;
    end
    n_checks++;
    if (gnt !== exp_gnt) begin
      $display("FAIL grant_onehot: gnt=%b required=%b", gnt, exp_gnt);
      n_fail++;
    end
    n_checks++;
    if (k !== 0) begin
      $display("FAIL grant_first_edge: waited=%0d required=0", k);
      n_fail++;
    end
    last_id = exp_id;
    sb.push_back(exp_id ? model(1'b1, op1, a1, b1) : model(1'b0, op0, a0, b0));
    if (!hold) req = '0;
    // Operands change after grant must not disturb the in-flight operation
    a0 = NBITS'($urandom); b0 = NBITS'($urandom);
    a1 = NBITS'($urandom); b1 = NBITS'($urandom);
    op0 = 2'($urandom);    op1 = 2'($urandom);
    if (exec_ack) res_ack = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= LAT + 5; i++) begin
      @(posedge clk_2); #1;
      res_ack = 1'b0;
      k = i;
      if (i == 1) begin
        n_checks++;
        if (gnt !== 2'b00 || busy !== 1'b1) begin
          $display("FAIL gnt_pulse_busy: gnt=%b busy=%b required gnt=00 busy=1", gnt, busy);
          n_fail++;
        end
      end
      if (res_valid === 1'b1) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    n_checks++;
    if (!got) begin
      $display("FAIL result_timeout: res_valid=%b required=1", res_valid);
      n_fail++;
      return;
    end
    n_checks++;
    if (k !== LAT) begin
      $display("FAIL latency: edges=%0d required=%0d", k, LAT);
      n_fail++;
    end
    n_checks++;
    if (result !== e.res || overflow !== e.ovf || res_id !== e.id) begin
      $display("FAIL result: result=%b ovf=%b id=%b required result=%b ovf=%b id=%b",
               result, overflow, res_id, e.res, e.ovf, e.id);
      n_fail++;
    end
    for (int i = 0; i < ack_delay; i++) begin
      @(posedge clk_2); #1;
      n_checks++;
      if (res_valid !== 1'b1 || result !== e.res || overflow !== e.ovf ||
          res_id !== e.id || gnt !== 2'b00) begin
        $display("FAIL hold_stable: valid=%b result=%b ovf=%b id=%b gnt=%b required 1 %b %b %b 00",
                 res_valid, result, overflow, res_id, gnt, e.res, e.ovf, e.id);
        n_fail++;
      end
    end
    res_ack = 1'b1;
    @(posedge clk_2); #1;
    res_ack = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00) begin
      $display("FAIL ack_clear: valid=%b busy=%b gnt=%b required 0 0 00", res_valid, busy, gnt);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; res_ack = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_id = 1'b1;
    #2;
    n_checks++;
    if ({gnt, busy, res_valid, result, overflow, res_id} !== '0) begin
      $display("FAIL reset_outputs: gnt=%b busy=%b valid=%b result=%b ovf=%b id=%b required all 0",
               gnt, busy, res_valid, result, overflow, res_id);
      n_fail++;
    end
    repeat (2) @(posedge clk_2);
    #1 reset = 1'b0;
  endtask

  task automatic test_add_sub();
    op0 = 2'b00; a0 = 3'sd3; b0 = 3'sd1;
    issue(2'b01, 1'b0, 1'b0, 0);
    op1 = 2'b01; a1 = -3'sd4; b1 = 3'sd1;
    issue(2'b10, 1'b0, 1'b0, 0);
    op1 = 2'b01; a1 = 3'sd2; b1 = -3'sd1;
    issue(2'b10, 1'b0, 1'b0, 0);
    op0 = 2'b00; a0 = -3'sd4; b0 = -3'sd1;
    issue(2'b01, 1'b0, 1'b0, 1);
  endtask

  task automatic test_logic();
    op0 = 2'b10; a0 = -3'sd1; b0 = 3'sd2;
    issue(2'b01, 1'b0, 1'b0, 0);
    op1 = 2'b11; a1 = 3'sd1; b1 = -3'sd4;
    issue(2'b10, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      op0 = 2'b00; a0 = 3'(i);     b0 = 3'sd1;
      op1 = 2'b01; a1 = 3'(i + 2); b1 = 3'sd3;
      issue(2'b11, 1'b1, 1'b0, 0);
    end
    req = '0;
  endtask

  task automatic test_ack_hold();
    op0 = 2'b01; a0 = 3'sd1; b0 = 3'sd2;
    issue(2'b01, 1'b0, 1'b1, 10);
  endtask

  task automatic test_reset_mid_exec();
    logic got;
    op0 = 2'b00; a0 = 3'sd1; b0 = 3'sd1;
    req = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_2); #1;
      if (gnt != 2'b00) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      $display("FAIL mid_exec_grant_timeout: gnt=%b required=01", gnt);
      n_fail++;
    end
    last_id = 1'b0;
    req = '0;
    @(posedge clk_2); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, res_valid, result, overflow, res_id} !== '0) begin
      $display("FAIL async_reset: gnt=%b busy=%b valid=%b result=%b ovf=%b id=%b required all 0",
               gnt, busy, res_valid, result, overflow, res_id);
      n_fail++;
    end
    last_id = 1'b1;
    repeat (3) begin
      @(posedge clk_2); #1;
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL reset_discard: valid=%b busy=%b required 0 0", res_valid, busy);
        n_fail++;
      end
    end
    reset = 1'b0;
    op0 = 2'b11; a0 = 3'sd2; b0 = 3'sd1;
    op1 = 2'b00; a1 = 3'sd1; b1 = 3'sd1;
    issue(2'b11, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_back_to_back();
    test_ack_hold();
    test_reset_mid_exec();
    repeat (2) @(posedge clk_2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
